muldiv_unit_iter: RTL and testbench
===================================

Name: muldiv_unit_iter

Overview:
Parametrised multi-cycle HI/LO multiply/divide unit for the 5-stage pipeline. It replaces the single-cycle 64-bit ALU product path and the HI/LO write-back path with an iterative shift-add multiplier and restoring divider, and owns the HI/LO registers. The unit sits beside the EXE-stage ALU. It raises Busy and a stall request so the hazard logic holds IF/ID when an instruction needs HI/LO before the result is ready.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
Clk  in  1  clock.
Rst  in  1  reset, asynchronous, active-high.
Start  in  1  request a new operation; sampled only in IDLE.
Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
Src_A  in  WIDTH  multiplicand / dividend (Rs).
Src_B  in  WIDTH  multiplier / divisor (Rt).
Abort  in  1  cancel the in-flight operation (branch/jump flush of the issuing instruction).
HI_write  in  1  MTHI.
LO_write  in  1  MTLO.
HILO_wdata  in  WIDTH  MTHI/MTLO data.
HILO_read  in  1  ID stage holds MFHI/MFLO.
HI  out  WIDTH  HI register.
LO  out  WIDTH  LO register.
Busy  out  1  operation in flight.
Done  out  1  one-cycle pulse; result is visible on HI/LO.
Div_by_zero  out  1  pulses with Done when a DIV/DIVU had Src_B==0.
Stall_req  out  1  equals Busy & (HILO_read | Start).

Behaviour:
- Reset: HI=0, LO=0, Busy=0, Done=0, Div_by_zero=0, state=IDLE, counter=0.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on Start.
  - RUN -> FIX when counter reaches WIDTH.
  - FIX -> IDLE unconditionally.
  - Any state -> IDLE on Abort.
- Accept: on the edge where IDLE & Start, latch Op, the sign flags and the operand magnitudes (two's-complement abs for MULT/DIV; raw for MULTU/DIVU). Counter=0.
- Multiply: one product bit per RUN cycle, 2*WIDTH-bit accumulator.
- Divide: one quotient bit per RUN cycle; remainder register is WIDTH+1 bits.
- FIX applies sign correction:
  - MULT: negate the 2W-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Latency for Start accepted at edge 0:
  - Busy=1 in cycles 1..WIDTH+1.
  - HI/LO updated at the end of cycle WIDTH+1.
  - Done=1 in cycle WIDTH+2 with Busy=0. For WIDTH=32, Done appears in cycle 34.
- Result mapping: multiply gives HI=product[2W-1:W], LO=product[W-1:0]. Divide gives LO=quotient, HI=remainder.
- Divide by zero: full latency still applies. Result is LO=all-ones, HI=Src_A as latched, and Div_by_zero pulses with Done.
- DIV of most-negative by -1: LO=most-negative (wraps), HI=0, no flag.
- Start while Busy: ignored, with no queueing. Stall_req holds the issuing instruction until IDLE, and it re-presents Start then.
- Start in the FIX cycle: ignored. It is accepted in the following IDLE cycle.
- MTHI/MTLO:
  - Write HI/LO on the next edge in any state.
  - An in-flight operation still overwrites both at completion.
  - Write and completion on the same edge: completion wins.
  - MTHI/MTLO with Start in IDLE on the same edge: the write applies now, and the operation result overwrites later.
- Abort: on the next edge, return to IDLE, Busy=0, HI/LO unchanged, no Done.
  - Abort in IDLE: no effect.
  - Abort together with Start in IDLE: Start is dropped.
- Rst mid-operation: immediate return to reset values; no Done.
- Done and Div_by_zero are registered single-cycle pulses.

Decomposition:
- Shared package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings: ST_IDLE, ST_RUN, ST_FIX.
- One sub-module, muldiv_step. It is a combinational single-iteration datapath: shift-add step or restoring-subtract step, selected by an is_div input. The top keeps the FSM, counter, operand/sign latches and HI/LO registers.

Test Plan:
- MULT Src_A=0xFFFFFFFD (-3), Src_B=7, WIDTH=32 -> Done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high cycles 1..33.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 -> LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, Div_by_zero=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, Div_by_zero=1 for exactly one cycle with Done.
- Preload HI=0x11 and LO=0x22 via MTHI/MTLO, then start MULT. Apply Abort in cycle 10 -> Busy=0 in cycle 11, no Done, HI=0x11, LO=0x22.
  - Repeat with Rst pulsed in cycle 10 instead -> HI=LO=0 immediately.
- During an in-flight MULT 2*3:
  - HILO_read=1 in cycle 5 -> Stall_req=1 until Busy falls.
  - Second Start in cycle 5 -> ignored.
  - MTHI 0xAA in cycle 12 -> HI=0xAA in cycle 13, then HI=0, LO=6 at Done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
//   op_e    : Op port encoding (MULT, MULTU, DIV, DIVU)
//   state_e : control FSM states
//   helpers : decode of the Op field into divide / signed flags
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   // Op[1] selects divide, Op[0] selects the unsigned variant.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   i_is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_hi     : upper accumulator (multiply) / partial remainder (divide), WIDTH+1 bits
//   i_lo     : multiplier bits still to consume / dividend bits still to shift in
//   i_b      : multiplicand / divisor magnitude
//   o_hi/o_lo: state after this iteration
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_is_div,
   input  logic [WIDTH:0]   i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_diff;
   logic           w_ge;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier bit is set,
      // then shift the whole {hi,lo} accumulator right by one. The carry
      // out of the add lands in the top of the shifted upper half.
      w_sum    = i_hi + (i_lo[0] ? {1'b0, i_b} : '0);

      // Divide: shift the next dividend bit into the remainder and try to
      // subtract the divisor; keep the difference only if it did not go negative.
      w_rem_sh = {i_hi[WIDTH-1:0], i_lo[WIDTH-1]};
      w_ge     = (w_rem_sh >= {1'b0, i_b});
      w_diff   = w_rem_sh - {1'b0, i_b};

      if (i_is_div) begin
         o_hi = w_ge ? w_diff : w_rem_sh;
         o_lo = {i_lo[WIDTH-2:0], w_ge};
      end else begin
         o_hi = {1'b0, w_sum[WIDTH:1]};
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit_iter.sv
// Iterative HI/LO multiply/divide unit; owns the HI and LO registers.
//   Clk, Rst          : clock, asynchronous active-high reset
//   Start, Op         : request (sampled in IDLE only) and operation select
//   Src_A, Src_B      : multiplicand/dividend, multiplier/divisor
//   Abort             : cancel the in-flight operation
//   HI_write, LO_write, HILO_wdata : MTHI / MTLO
//   HILO_read         : ID stage holds MFHI/MFLO
//   HI, LO            : architectural HI/LO
//   Busy, Done        : operation in flight / one-cycle completion pulse
//   Div_by_zero       : pulses with Done for a divide by zero
//   Stall_req         : Busy & (HILO_read | Start)
module muldiv_unit_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] Src_A,
   input  logic [WIDTH-1:0] Src_B,
   input  logic             Abort,
   input  logic             HI_write,
   input  logic             LO_write,
   input  logic [WIDTH-1:0] HILO_wdata,
   input  logic             HILO_read,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Done,
   output logic             Div_by_zero,
   output logic             Stall_req
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             r_state, w_nstate;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic               r_neg_q;     // product / quotient must be negated
   logic               r_neg_r;     // remainder takes the dividend's sign
   logic               r_dbz;       // latched divisor == 0 for a divide
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH:0]     r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_done, r_dz_pulse;

   logic               w_accept, w_step, w_finish;
   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH:0]     w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
   logic [WIDTH-1:0]   w_res_hi, w_res_lo;

   // ---------------- control FSM ----------------
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= ST_IDLE;
      else     r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_nstate = ST_RUN;
               w_accept = 1'b1;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            // The counter reaches WIDTH on the same edge as the last step.
            if (r_cnt == CNT_W'(WIDTH - 1)) w_nstate = ST_FIX;
         end
         ST_FIX: begin
            w_nstate = ST_IDLE;
            w_finish = 1'b1;
         end
         default: w_nstate = ST_IDLE;
      endcase
      // Abort cancels everything, including a Start presented in IDLE.
      if (Abort) begin
         w_nstate = ST_IDLE;
         w_accept = 1'b0;
         w_step   = 1'b0;
         w_finish = 1'b0;
      end
   end

   // ---------------- operand magnitudes ----------------
   always_comb begin
      w_a_neg = op_is_signed(Op) & Src_A[WIDTH-1];
      w_b_neg = op_is_signed(Op) & Src_B[WIDTH-1];
      w_a_mag = w_a_neg ? -Src_A : Src_A;
      w_b_mag = w_b_neg ? -Src_B : Src_B;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_hi     (r_acc_hi),
      .i_lo     (r_acc_lo),
      .i_b      (r_b),
      .o_hi     (w_step_hi),
      .o_lo     (w_step_lo)
   );

   // ---------------- iteration datapath ----------------
   // Both operations use the same layout: lo starts as |A| (multiplier or
   // dividend), b holds |B| (multiplicand or divisor), hi starts at zero.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dbz    <= 1'b0;
         r_b      <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_is_div <= op_is_div(Op);
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_dbz    <= op_is_div(Op) & (Src_B == '0);
         r_b      <= w_b_mag;
         r_acc_hi <= '0;
         r_acc_lo <= w_a_mag;
      end else if (w_step) begin
         r_cnt    <= r_cnt + 1'b1;
         r_acc_hi <= w_step_hi;
         r_acc_lo <= w_step_lo;
      end
   end

   // ---------------- sign fix-up ----------------
   // Divide by zero leaves |A| in the remainder, so the sign fix already
   // gives back A; only the quotient needs forcing to all-ones.
   always_comb begin
      w_prod     = {r_acc_hi[WIDTH-1:0], r_acc_lo};
      w_prod_fix = r_neg_q ? -w_prod : w_prod;
      w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
      w_rem_fix  = r_neg_r ? -r_acc_hi[WIDTH-1:0] : r_acc_hi[WIDTH-1:0];
      if (r_is_div) begin
         w_res_hi = w_rem_fix;
         w_res_lo = r_dbz ? '1 : w_quo_fix;
      end else begin
         w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod_fix[WIDTH-1:0];
      end
   end

   // ---------------- HI/LO and pulses ----------------
   // Completion has priority over a same-edge MTHI/MTLO.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_dz_pulse <= 1'b0;
      end else begin
         r_done     <= w_finish;
         r_dz_pulse <= w_finish & r_is_div & r_dbz;
         if (w_finish) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else begin
            if (HI_write) r_hi <= HILO_wdata;
            if (LO_write) r_lo <= HILO_wdata;
         end
      end
   end

   assign HI          = r_hi;
   assign LO          = r_lo;
   assign Busy        = (r_state != ST_IDLE);
   assign Done        = r_done;
   assign Div_by_zero = r_dz_pulse;
   assign Stall_req   = Busy & (HILO_read | Start);

endmodule

// File: tb/tb_muldiv_unit_iter.sv
module tb_muldiv_unit_iter;

   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          Start = 1'b0;
   logic [1:0]    Op = 2'b00;
   logic [W-1:0]  Src_A = '0, Src_B = '0;
   logic          Abort = 1'b0;
   logic          HI_write = 1'b0, LO_write = 1'b0;
   logic [W-1:0]  HILO_wdata = '0;
   logic          HILO_read = 1'b0;
   logic [W-1:0]  HI, LO;
   logic          Busy, Done, Div_by_zero, Stall_req;

   int total = 0;
   int bad   = 0;

   muldiv_unit_iter #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Src_A(Src_A), .Src_B(Src_B),
      .Abort(Abort), .HI_write(HI_write), .LO_write(LO_write), .HILO_wdata(HILO_wdata),
      .HILO_read(HILO_read), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done),
      .Div_by_zero(Div_by_zero), .Stall_req(Stall_req)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
   function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
      longint sa, sb, ua, ub, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      dz = 1'b0;
      p  = '0;
      case (op)
         2'b00: p = sa * sb;
         2'b01: p = {32'b0, a} * {32'b0, b};
         default: begin
            if (b == '0) begin
               dz = 1'b1;
               p  = {a, 32'hFFFF_FFFF};
            end else begin
               q = (op == 2'b10) ? sa / sb : ua / ub;
               r = (op == 2'b10) ? sa % sb : ua % ub;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      hi = p[63:32];
      lo = p[31:0];
   endfunction

   // Issue one operation from IDLE and check the whole latency window.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ehi, elo;
      logic edz;
      int busy_bad;
      model(op, a, b, ehi, elo, edz);
      @(negedge Clk);                       // cycle 0
      Op = op; Src_A = a; Src_B = b; Start = 1'b1;
      busy_bad = 0;
      for (int c = 1; c <= W + 1; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         if (Busy !== 1'b1 || Done !== 1'b0) busy_bad++;
      end
      chk("busy_window", 64'(busy_bad), 64'd0);
      @(negedge Clk);                       // cycle W+2
      chk("done",  {63'd0, Done}, 64'd1);
      chk("busy_off", {63'd0, Busy}, 64'd0);
      chk("hi", {32'd0, HI}, {32'd0, ehi});
      chk("lo", {32'd0, LO}, {32'd0, elo});
      chk("dbz", {63'd0, Div_by_zero}, {63'd0, edz});
      @(negedge Clk);
      chk("pulse_len", {62'd0, Done, Div_by_zero}, 64'd0);
   endtask

   task automatic preload(input logic [W-1:0] h, input logic [W-1:0] l);
      @(negedge Clk); HI_write = 1'b1; HILO_wdata = h;
      @(negedge Clk); HI_write = 1'b0; LO_write = 1'b1; HILO_wdata = l;
      @(negedge Clk); LO_write = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [W-1:0] ehi, elo;
      logic edz;
      logic [1:0] rop;
      logic [W-1:0] ra, rb;

      // ---- reset ----
      repeat (2) @(negedge Clk);
      chk("rst_hilo", {HI, LO}, 64'd0);
      chk("rst_flags", {61'd0, Busy, Done, Div_by_zero}, 64'd0);
      Rst = 1'b0;
      @(negedge Clk);
      chk("post_rst", {61'd0, Busy, Done, Div_by_zero}, 64'd0);

      // ---- directed ----
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd100, 32'd7);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd5, 32'd0);
      run_op(2'b10, 32'hFFFF_FFFB, 32'd0);

      // ---- randomized ----
      for (int i = 0; i < 16; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 9));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: ra = 32'($urandom_range(0, 50));
            default: ;
         endcase
         run_op(rop, ra, rb);
      end

      // ---- abort in cycle 10 ----
      preload(32'h11, 32'h22);
      @(negedge Clk); Op = 2'b00; Src_A = 32'd1234; Src_B = 32'd77; Start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         Abort = (c == 10);
      end
      @(negedge Clk); Abort = 1'b0;          // cycle 11
      chk("abort_busy", {63'd0, Busy}, 64'd0);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if (Done !== 1'b0) cnt++;
      end
      chk("abort_no_done", 64'(cnt), 64'd0);
      chk("abort_hilo", {HI, LO}, {32'h11, 32'h22});

      // ---- reset in cycle 10 ----
      preload(32'h11, 32'h22);
      @(negedge Clk); Op = 2'b00; Src_A = 32'd1234; Src_B = 32'd77; Start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         Start = 1'b0;
      end
      Rst = 1'b1;
      #1;
      chk("midrst_hilo", {HI, LO}, 64'd0);
      chk("midrst_busy", {63'd0, Busy}, 64'd0);
      @(negedge Clk); Rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if (Done !== 1'b0) cnt++;
      end
      chk("midrst_no_done", 64'(cnt), 64'd0);

      // ---- stall, ignored second Start, MTHI in flight ----
      @(negedge Clk); Op = 2'b00; Src_A = 32'd2; Src_B = 32'd3; Start = 1'b1;
      cnt = 0;
      for (int c = 1; c <= 34; c++) begin
         @(negedge Clk);
         Start = (c == 5);
         if (c == 5) begin Op = 2'b11; Src_A = 32'd99; Src_B = 32'd4; HILO_read = 1'b1; end
         HI_write = (c == 12);
         HILO_wdata = 32'hAA;
         #1;
         if (c >= 5 && c <= 33 && Stall_req !== 1'b1) cnt++;
         if (c == 4)  chk("stall_idle_read", {63'd0, Stall_req}, 64'd0);
         if (c == 13) chk("mthi_inflight", {32'd0, HI}, 64'hAA);
         if (c == 34) begin
            chk("stall_done", {63'd0, Done}, 64'd1);
            chk("stall_hilo", {HI, LO}, {32'd0, 32'd6});
            chk("stall_release", {63'd0, Stall_req}, 64'd0);
         end
      end
      chk("stall_window", 64'(cnt), 64'd0);
      HILO_read = 1'b0;
      @(negedge Clk);
      chk("second_start_ignored", {63'd0, Busy}, 64'd0);

      // ---- Start presented in FIX is taken in the following IDLE ----
      model(2'b11, 32'd1000, 32'd33, ehi, elo, edz);
      @(negedge Clk); Op = 2'b01; Src_A = 32'd5; Src_B = 32'd6; Start = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge Clk);
         Start = (c == 33 || c == 34);
         if (c == 33) begin Op = 2'b11; Src_A = 32'd1000; Src_B = 32'd33; end
      end
      #1;
      chk("fix_start_busy", {62'd0, Busy, Done}, 64'd1);
      chk("fix_first_res", {HI, LO}, 64'd30);
      @(negedge Clk); Start = 1'b0;          // cycle 35 = cycle 1 of second op
      chk("fix_start_taken", {63'd0, Busy}, 64'd1);
      repeat (33) @(negedge Clk);
      chk("fix_second_done", {63'd0, Done}, 64'd1);
      chk("fix_second_res", {HI, LO}, {ehi, elo});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
